// File: rtl/pll_rst_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
package pll_rst_pkg;

  // Qualification states, in the order the sequencer walks through them.
  typedef enum logic [1:0] {
    StWaitLock,
    StStable,
    StHold,
    StRun
  } state_e;

  localparam int unsigned DefSyncStages       = 2;
  localparam int unsigned DefLockStableCycles = 1024;
  localparam int unsigned DefRstHoldCycles    = 16;
  localparam int unsigned DefCeDiv            = 2;

  // Width of the saturating lock-loss counter.
  localparam int unsigned LOCK_CNT_W = 8;

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL/consumer side (master) and the sequencer (slave).
interface pll_reset_sequencer_if;
  import pll_rst_pkg::*;

  logic                  lock;
  logic                  sys_rst;
  logic                  ready;
  logic                  ce;
  logic [LOCK_CNT_W-1:0] lock_lost_cnt;

  modport master (
    output lock,
    input  sys_rst,
    input  ready,
    input  ce,
    input  lock_lost_cnt
  );

  modport slave (
    input  lock,
    output sys_rst,
    output ready,
    output ce,
    output lock_lost_cnt
  );

endinterface

// File: rtl/lock_sync.sv
// N-stage synchronizer for the raw PLL lock, cleared by async active-high reset.
module lock_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  // Shift the raw input through the flop chain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: qualifies a synchronized lock for LOCK_STABLE_CYCLES, holds
// reset RST_HOLD_CYCLES more, then releases sys_rst and raises ready.
// Optional feature macro: PLL_RST_CE_DIV_EN (divided clock-enable strobe in RUN);
// when undefined, ce simply mirrors ready.
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = DefSyncStages,
  parameter int unsigned LOCK_STABLE_CYCLES = DefLockStableCycles,
  parameter int unsigned RST_HOLD_CYCLES    = DefRstHoldCycles,
  parameter int unsigned CE_DIV             = DefCeDiv
) (
  input logic                  clk,
  input logic                  rst,
  pll_reset_sequencer_if.slave pll_if
);

  localparam int unsigned CntMax = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                                   LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] StableLast = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLast   = CntW'(RST_HOLD_CYCLES - 1);

  // Reject illegal configurations at elaboration.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (LOCK_STABLE_CYCLES < 1 || RST_HOLD_CYCLES < 1 || CE_DIV < 1) begin : g_bad_cycles
    $error("LOCK_STABLE_CYCLES, RST_HOLD_CYCLES and CE_DIV must be at least 1");
  end

  logic                  lock_s;
  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [LOCK_CNT_W-1:0] lost_q, lost_d;
  logic                  sys_rst_q, sys_rst_d;
  logic                  ready_q, ready_d;

  lock_sync #(
    .Stages (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (pll_if.lock),
    .q_o   (lock_s)
  );

  // Next-state, qualification counter and lock-loss bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    unique case (state_q)
      StWaitLock: begin
        cnt_d = '0;
        if (lock_s) state_d = StStable;
      end
      StStable: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == HoldLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          if (lost_q != '1) lost_d = lost_q + LOCK_CNT_W'(1);
        end
      end
      default: state_d = StWaitLock;
    endcase
    // Outputs follow the next state so they switch on the same edge as the state.
    sys_rst_d = (state_d != StRun);
    ready_d   = (state_d == StRun);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StWaitLock;
      cnt_q     <= '0;
      lost_q    <= '0;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lost_q    <= lost_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
    end
  end

  assign pll_if.sys_rst       = sys_rst_q;
  assign pll_if.ready         = ready_q;
  assign pll_if.lock_lost_cnt = lost_q;

`ifdef PLL_RST_CE_DIV_EN
  localparam int unsigned DivW = $clog2(CE_DIV + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(CE_DIV);

  // div holds the 1-based position of the coming RUN cycle within the CE period.
  logic [DivW-1:0] div_q, div_d;
  logic            ce_q, ce_d;

  // Divider restarts on RUN entry and is zeroed outside RUN.
  always_comb begin
    div_d = '0;
    if (state_d == StRun) begin
      if (state_q != StRun || div_q == DivLast) begin
        div_d = DivW'(1);
      end else begin
        div_d = div_q + DivW'(1);
      end
    end
    ce_d = (state_d == StRun) && (div_d == DivLast);
  end

  // Divider and strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      ce_q  <= ce_d;
    end
  end

  assign pll_if.ce = ce_q;
`else
  assign pll_if.ce = ready_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: vector table, corner-case sequences
// and randomized lock patterns against a streak-based reference model.
module tb_pll_reset_sequencer;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned StableCyc  = 8;
  localparam int unsigned HoldCyc    = 4;
  localparam int unsigned CeDiv      = 3;
  // Lock must be seen (after synchronization) on this many consecutive edges to run.
  localparam int          Qual       = 1 + StableCyc + HoldCyc;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  pll_reset_sequencer_if pif ();

  pll_reset_sequencer #(
    .SYNC_STAGES        (SyncStages),
    .LOCK_STABLE_CYCLES (StableCyc),
    .RST_HOLD_CYCLES    (HoldCyc),
    .CE_DIV             (CeDiv)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .pll_if (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: delayed lock samples plus a streak of consecutive seen-high edges.
  bit sq[$];
  int streak;
  int lost;

  function automatic void model_reset();
    sq.delete();
    for (int i = 0; i < SyncStages; i++) sq.push_back(1'b0);
    streak = 0;
    lost   = 0;
  endfunction

  function automatic void model_edge(input bit l);
    bit ls;
    ls = sq.pop_front();
    sq.push_back(l);
    if (ls) begin
      streak++;
    end else begin
      if (streak >= Qual && lost < 255) lost++;
      streak = 0;
    end
  endfunction

  function automatic bit m_ready();
    return streak >= Qual;
  endfunction

  function automatic bit m_ce();
`ifdef PLL_RST_CE_DIV_EN
    return m_ready() && (((streak - Qual + 1) % CeDiv) == 0);
`else
    return m_ready();
`endif
  endfunction

  task automatic check_model(input string tag);
    tests++;
    if (pif.sys_rst !== !m_ready() || pif.ready !== m_ready() || pif.ce !== m_ce() ||
        pif.lock_lost_cnt !== 8'(lost)) begin
      fails++;
      $display("FAIL %s t=%0t: got sys_rst=%0b ready=%0b ce=%0b cnt=%0d, expected %0b %0b %0b %0d",
               tag, $time, pif.sys_rst, pif.ready, pif.ce, pif.lock_lost_cnt,
               !m_ready(), m_ready(), m_ce(), lost);
    end
  endtask

  task automatic expect_int(input string tag, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s t=%0t: got %0d, expected %0d", tag, $time, got, want);
    end
  endtask

  // Drive lock for the next edge, advance the model, then compare just after the edge.
  task automatic step(input bit l, input string tag);
    @(negedge clk);
    pif.lock = l;
    @(posedge clk);
    model_edge(l);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  typedef struct {
    bit lock;
    int n;
    bit sys_rst;
    bit ready;
    bit ce_div;
    int cnt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int k;
    bit want_ce;
    rst      = 1'b1;
    pif.lock = 1'b0;
    tests    = 0;
    fails    = 0;
    model_reset();

    // Hold lock high, run, lose lock once, requalify.
    tbl[0] = '{lock: 1'b1, n: 14, sys_rst: 1'b1, ready: 1'b0, ce_div: 1'b0, cnt: 0};
    tbl[1] = '{lock: 1'b1, n: 1,  sys_rst: 1'b0, ready: 1'b1, ce_div: 1'b0, cnt: 0};
    tbl[2] = '{lock: 1'b1, n: 5,  sys_rst: 1'b0, ready: 1'b1, ce_div: 1'b1, cnt: 0};
    tbl[3] = '{lock: 1'b0, n: 2,  sys_rst: 1'b0, ready: 1'b1, ce_div: 1'b0, cnt: 0};
    tbl[4] = '{lock: 1'b0, n: 1,  sys_rst: 1'b1, ready: 1'b0, ce_div: 1'b0, cnt: 1};
    tbl[5] = '{lock: 1'b1, n: 14, sys_rst: 1'b1, ready: 1'b0, ce_div: 1'b0, cnt: 1};
    tbl[6] = '{lock: 1'b1, n: 1,  sys_rst: 1'b0, ready: 1'b1, ce_div: 1'b0, cnt: 1};

    // Reset state while rst is held.
    repeat (2) @(posedge clk);
    #1;
    check_model("reset_held");
    expect_int("reset_sys_rst", int'(pif.sys_rst), 1);
    expect_int("reset_ce", int'(pif.ce), 0);
    #1;
    rst = 1'b0;

    for (int r = 0; r < 7; r++) begin
      for (int i = 0; i < tbl[r].n; i++) step(tbl[r].lock, "tbl_step");
`ifdef PLL_RST_CE_DIV_EN
      want_ce = tbl[r].ce_div;
`else
      want_ce = tbl[r].ready;
`endif
      expect_int($sformatf("tbl%0d_sys_rst", r), int'(pif.sys_rst), int'(tbl[r].sys_rst));
      expect_int($sformatf("tbl%0d_ready", r), int'(pif.ready), int'(tbl[r].ready));
      expect_int($sformatf("tbl%0d_ce", r), int'(pif.ce), int'(want_ce));
      expect_int($sformatf("tbl%0d_cnt", r), int'(pif.lock_lost_cnt), tbl[r].cnt);
    end

    // Asynchronous reset between edges while in RUN with a nonzero loss count.
    #3;
    rst = 1'b1;
    #1;
    expect_int("async_sys_rst", int'(pif.sys_rst), 1);
    expect_int("async_ready", int'(pif.ready), 0);
    expect_int("async_ce", int'(pif.ce), 0);
    expect_int("async_cnt", int'(pif.lock_lost_cnt), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 14; i++) step(1'b1, "requal_step");
    expect_int("requal_14_sys_rst", int'(pif.sys_rst), 1);
    step(1'b1, "requal_step");
    expect_int("requal_15_sys_rst", int'(pif.sys_rst), 0);

    // One-cycle lock dropout during STABLE restarts qualification.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, "s2_step");
    step(1'b0, "s2_step");
    k = 0;
    do begin
      step(1'b1, "s2_step");
      k++;
    end while (pif.sys_rst && k < 40);
    expect_int("s2_edges_after_rerise", k, 15);

    // CE pattern over the first nine RUN cycles.
    do_reset();
    for (int i = 0; i < 15; i++) step(1'b1, "s4_step");
    for (int i = 1; i <= 9; i++) begin
      if (i > 1) step(1'b1, "s4_step");
`ifdef PLL_RST_CE_DIV_EN
      want_ce = ((i % CeDiv) == 0);
`else
      want_ce = 1'b1;
`endif
      expect_int($sformatf("s4_ce_cycle%0d", i), int'(pif.ce), int'(want_ce));
    end

    // 300 lock losses saturate the counter at 255.
    do_reset();
    for (int c = 1; c <= 300; c++) begin
      for (int i = 0; i < 15; i++) step(1'b1, "s5_step");
      for (int i = 0; i < 3; i++) step(1'b0, "s5_step");
      if (c == 254) expect_int("s5_cnt_254", int'(pif.lock_lost_cnt), 254);
    end
    expect_int("s5_cnt_sat", int'(pif.lock_lost_cnt), 255);

    // Randomized lock runs with occasional resets.
    do_reset();
    for (int r = 0; r < 300; r++) begin
      if ($urandom_range(0, 19) == 0) do_reset();
      for (int i = $urandom_range(1, 20); i > 0; i--) step(1'b1, "rand_step");
      for (int i = $urandom_range(1, 4); i > 0; i--) step(1'b0, "rand_step");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of flops in the lock synchronizer (minimum 2).
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before the hold phase (minimum 1).
REQ-003 SHALL have parameter RST_HOLD_CYCLES, default 16: extra reset cycles after lock qualifies (minimum 1).
REQ-004 SHALL have parameter CE_DIV, default 2: clock-enable divide ratio (minimum 1).
REQ-005 SHALL have port clk, input, 1: system clock, the PLL clkout domain; single clock.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port lock, input, 1: raw PLL lock, asynchronous to clk.
REQ-008 SHALL have port sys_rst, output, 1: active-high downstream reset, registered.
REQ-009 SHALL have port ready, output, 1: high only in state RUN.
REQ-010 SHALL have port ce, output, 1: single-cycle clock-enable strobe.
REQ-011 SHALL have port lock_lost_cnt, output, 8: saturating count of lock losses seen in RUN.

Function
REQ-012 SHALL pass lock through a SYNC_STAGES flop chain; its last stage is lock_s, and only lock_s drives logic.
REQ-013 SHALL implement states WAIT_LOCK, STABLE, HOLD and RUN.
REQ-014 WAIT_LOCK: on lock_s=1, go to STABLE with the counter at 0.
REQ-015 STABLE: increment the counter each cycle; on lock_s=0 go to WAIT_LOCK; when the counter = LOCK_STABLE_CYCLES-1 and lock_s=1, go to HOLD with the counter at 0.
REQ-016 HOLD: increment the counter each cycle; on lock_s=0 go to WAIT_LOCK; when the counter = RST_HOLD_CYCLES-1, go to RUN.
REQ-017 RUN: on lock_s=0 go to WAIT_LOCK; otherwise remain in RUN.
REQ-018 Registered outputs sys_rst and ready SHALL be computed from the next state, so they change on the same edge as the state.
REQ-019 sys_rst SHALL be 1 in every state except RUN.
REQ-020 sys_rst SHALL fall exactly SYNC_STAGES+1+LOCK_STABLE_CYCLES+RST_HOLD_CYCLES rising edges after the first edge that samples lock=1, provided lock stays high.
REQ-021 sys_rst SHALL rise SYNC_STAGES+1 edges after the first edge that samples lock=0 in RUN.
REQ-022 Any lock_s drop in STABLE or HOLD SHALL restart qualification from WAIT_LOCK; there is no partial credit.
REQ-023 lock_lost_cnt SHALL increment by 1 on each RUN->WAIT_LOCK transition, saturate at 255, and never wrap.
REQ-024 Counters SHALL be sized to hold max(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES)-1.

Reset
REQ-025 rst SHALL asynchronously force: the synchronizer to 0, the state to WAIT_LOCK, counters to 0, sys_rst=1, ready=0, ce=0, lock_lost_cnt=0.
REQ-026 rst asserted mid-operation, including in RUN, SHALL NOT increment lock_lost_cnt.
REQ-027 After rst releases, the full qualification sequence SHALL be required even if lock is already high.

Configuration
REQ-028 With macro PLL_RST_CE_DIV_EN defined: a divider counter SHALL run only in RUN and be cleared on RUN entry and exit.
REQ-029 With PLL_RST_CE_DIV_EN defined: ce SHALL pulse 1 every CE_DIV cycles, the first pulse on the CE_DIV-th cycle in RUN; CE_DIV=1 gives ce=1 throughout RUN; ce=0 outside RUN.
REQ-030 With PLL_RST_CE_DIV_EN undefined: there SHALL be no divider logic, ce SHALL equal ready, and CE_DIV SHALL be ignored.

Structure
REQ-031 Package pll_rst_pkg SHALL hold the state enum type, the default parameter constants, and the LOCK_CNT_W=8 saturation width.
REQ-032 Sub-module lock_sync SHALL be a parameterised N-stage synchronizer with async active-high reset; it is the only sub-module.

Verification
REQ-033 Use SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, RST_HOLD_CYCLES=4, CE_DIV=3 for all scenarios.
REQ-034 Scenario 1: rst release, lock rises at edge 0 and stays high -> sys_rst falls and ready rises at edge 15; lock_lost_cnt=0.
REQ-035 Scenario 2: lock low for one cycle during STABLE (edge 7) -> return to WAIT_LOCK; sys_rst falls 15 edges after the re-rise.
REQ-036 Scenario 3: in RUN, lock drops -> sys_rst=1 and ready=0 after 3 edges; lock_lost_cnt 0->1.
REQ-037 Scenario 4: with the macro defined, in RUN -> ce high on RUN cycles 3, 6, 9 and low otherwise; undefined -> ce tracks ready.
REQ-038 Scenario 5: 300 lock-loss cycles -> lock_lost_cnt stays at 255.
REQ-039 Scenario 6: rst asserted asynchronously in RUN between edges -> immediate sys_rst=1, ce=0, lock_lost_cnt=0; full 15-edge requalification follows.
